des_job_sched: RTL and testbench

- Job scheduler that sequences the 3DES encrypt datapath.
- Accepts host job descriptors (mode, length, destination address) into a 4-entry queue and issues them one at a time.
- Per job: drives the datapath's start/length/encrypt_data_addr, waits for its stop report, then posts a completion record.
- Adds a watchdog that aborts and soft-resets a hung datapath; sits between the host/bus interface and the encryption top.

---
 rtl/des_sched_pkg.sv | 29 ++
 rtl/job_fifo.sv | 41 ++++
 rtl/des_job_sched.sv | 189 ++++++++++++++++++
 tb/tb_des_job_sched.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_sched_pkg.sv
// Shared constants, descriptor layout and FSM encoding for the 3DES job scheduler.
package des_sched_pkg;

  localparam logic [1:0] MODE_ENC   = 2'b01;
  localparam logic [1:0] MODE_DEC   = 2'b10;
  localparam logic [2:0] ST_ILLEGAL = 3'b111;

  localparam int unsigned DESC_W = 22;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain,
    StRecover
  } sched_state_e;

  typedef struct packed {
    logic [1:0] mode;
    logic [8:0] len;
    logic [8:0] dst;
    logic [1:0] tag;
  } job_desc_t;

  function automatic logic job_legal(logic [1:0] mode, logic [8:0] len);
    return ((mode == MODE_ENC) || (mode == MODE_DEC)) && (len != 9'd0);
  endfunction

endpackage

// File: rtl/job_fifo.sv
// Descriptor queue: synchronous FIFO with wrap-bit pointers, async active-high reset.
module job_fifo import des_sched_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = DESC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + PTR_ONE;
      if (pop && !empty) rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  // Same slot, different lap: the queue is full.
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

endmodule

// File: rtl/des_job_sched.sv
// Job scheduler for the 3DES datapath: queues host descriptors, runs them one at a time,
// posts completion records and recovers a hung engine through a watchdog and soft reset.
module des_job_sched import des_sched_pkg::*; #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       job_valid,
  output logic       job_ready,
  input  logic [1:0] job_mode,
  input  logic [8:0] job_len,
  input  logic [8:0] job_dst,
  output logic [1:0] job_tag,
  output logic [1:0] eng_start,
  output logic [8:0] eng_length,
  output logic [8:0] eng_dst,
  input  logic [2:0] eng_stop,
  output logic       eng_srst,
  output logic       done_valid,
  output logic [1:0] done_tag,
  output logic [2:0] done_status,
  output logic       done_timeout,
  output logic       busy
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SRST_LAST = CW'(RST_CYCLES - 1);

  sched_state_e state_q, state_d;
  job_desc_t    work_q, work_d, head, push_desc;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   stop_q, stop_d;
  logic [1:0]   tag_q, pend_tag_q;
  logic         pend_q;
  logic         fifo_full, fifo_empty, pop;
  logic         accept, ill_now, fsm_post, fsm_timeout;
  logic         done_valid_q, done_timeout_q;
  logic [1:0]   done_tag_q;
  logic [2:0]   done_status_q;

  // A held illegal report blocks new pushes so it cannot be overtaken.
  assign job_ready = !fifo_full && !pend_q;
  assign job_tag   = tag_q;
  assign accept    = job_valid && job_ready;
  assign ill_now   = accept && !job_legal(job_mode, job_len);
  assign busy      = (state_q != StIdle) || !fifo_empty;
  assign push_desc = '{mode: job_mode, len: job_len, dst: job_dst, tag: tag_q};

  job_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(DESC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept && !ill_now),
    .wdata (push_desc),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    cnt_d       = cnt_q + CNT_ONE;
    stop_d      = stop_q;
    pop         = 1'b0;
    fsm_post    = 1'b0;
    fsm_timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          work_d  = head;
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        // A stop report on the final watchdog cycle still counts as a normal finish.
        if (eng_stop != 3'b000) begin
          stop_d  = eng_stop;
          cnt_d   = '0;
          state_d = StDrain;
        end else if (cnt_q == WDOG_LAST) begin
          cnt_d   = '0;
          state_d = StRecover;
        end
      end
      StDrain: begin
        if (eng_stop == 3'b000) begin
          fsm_post = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == WDOG_LAST) begin
          cnt_d   = '0;
          state_d = StRecover;
        end
      end
      StRecover: begin
        if (cnt_q == SRST_LAST) begin
          fsm_post    = 1'b1;
          fsm_timeout = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    eng_start  = 2'b00;
    eng_length = '0;
    eng_dst    = '0;
    eng_srst   = 1'b0;
    unique case (state_q)
      StLoad, StDrain: begin
        eng_length = work_q.len;
        eng_dst    = work_q.dst;
      end
      StRun: begin
        eng_length = work_q.len;
        eng_dst    = work_q.dst;
        if (eng_stop == 3'b000) eng_start = work_q.mode;
      end
      StRecover: begin
        eng_length = work_q.len;
        eng_dst    = work_q.dst;
        eng_srst   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_q         <= '0;
      cnt_q          <= '0;
      stop_q         <= '0;
      tag_q          <= '0;
      pend_q         <= 1'b0;
      pend_tag_q     <= '0;
      done_valid_q   <= 1'b0;
      done_tag_q     <= '0;
      done_status_q  <= '0;
      done_timeout_q <= 1'b0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      stop_q <= stop_d;
      if (accept) tag_q <= tag_q + 2'd1;
      pend_q <= ill_now && fsm_post;
      if (ill_now && fsm_post) pend_tag_q <= tag_q;
      done_valid_q <= fsm_post || pend_q || ill_now;
      if (fsm_post) begin
        done_tag_q     <= work_q.tag;
        done_status_q  <= fsm_timeout ? 3'b000 : stop_q;
        done_timeout_q <= fsm_timeout;
      end else if (pend_q || ill_now) begin
        done_tag_q     <= pend_q ? pend_tag_q : tag_q;
        done_status_q  <= ST_ILLEGAL;
        done_timeout_q <= 1'b0;
      end else begin
        done_tag_q     <= '0;
        done_status_q  <= '0;
        done_timeout_q <= 1'b0;
      end
    end
  end

  assign done_valid   = done_valid_q;
  assign done_tag     = done_tag_q;
  assign done_status  = done_status_q;
  assign done_timeout = done_timeout_q;

endmodule

// File: tb/tb_des_job_sched.sv
// Scoreboard bench for des_job_sched: a behavioural engine model predicts each completion.
module tb_des_job_sched;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned TIMEOUT    = 32;
  localparam int unsigned RST_CYCLES = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       job_valid = 1'b0;
  logic       job_ready;
  logic [1:0] job_mode = 2'b00;
  logic [8:0] job_len = 9'd0;
  logic [8:0] job_dst = 9'd0;
  logic [1:0] job_tag;
  logic [1:0] eng_start;
  logic [8:0] eng_length;
  logic [8:0] eng_dst;
  logic [2:0] eng_stop = 3'b000;
  logic       eng_srst;
  logic       done_valid;
  logic [1:0] done_tag;
  logic [2:0] done_status;
  logic       done_timeout;
  logic       busy;

  des_job_sched #(
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_mode     (job_mode),
    .job_len      (job_len),
    .job_dst      (job_dst),
    .job_tag      (job_tag),
    .eng_start    (eng_start),
    .eng_length   (eng_length),
    .eng_dst      (eng_dst),
    .eng_stop     (eng_stop),
    .eng_srst     (eng_srst),
    .done_valid   (done_valid),
    .done_tag     (done_tag),
    .done_status  (done_status),
    .done_timeout (done_timeout),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0] mode;
    logic [8:0] len;
    logic [8:0] dst;
    logic [1:0] tag;
  } desc_t;
  typedef struct {
    logic [1:0] tag;
    logic [2:0] status;
    logic       timeout;
  } done_t;
  // k = RUN cycle on which the engine reports (0 = never); hold = extra cycles stop stays up.
  typedef struct {
    int         k;
    logic [2:0] code;
    int         hold;
  } plan_t;
  typedef struct {
    logic [1:0] tag;
    int         cyc;
  } ill_t;

  desc_t ldesc_q[$];
  done_t exp_q[$];
  ill_t  ill_q[$];
  plan_t plan_q[$];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  logic [1:0] tag_model = 2'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(string name, string msg);
    n_checks++;
    n_err++;
    $display("FAIL %s: %s (t=%0t)", name, msg, $time);
  endtask

  function automatic plan_t rand_plan();
    plan_t p;
    int r;
    r = int'($urandom_range(0, 99));
    p.code = 3'($urandom_range(1, 6));
    p.hold = int'($urandom_range(0, 3));
    if (r < 15)      p.k = 0;
    else if (r < 25) p.k = TIMEOUT;
    else             p.k = int'($urandom_range(1, 12));
    return p;
  endfunction

  // Engine model: serves jobs in queue order and predicts each completion record.
  task automatic run_job();
    desc_t d;
    plan_t p;
    int    n;
    int    s;
    if (ldesc_q.size() == 0) begin
      fail("start_unexpected", $sformatf("eng_start=%0d with no legal job pending", eng_start));
      s = 0;
      while (eng_start != 2'b00 && s < TIMEOUT + 8 && !reset) begin
        @(negedge clk);
        s++;
      end
      return;
    end
    d = ldesc_q.pop_front();
    chk("eng_start_mode", 32'(eng_start), 32'(d.mode));
    chk("eng_length", 32'(eng_length), 32'(d.len));
    chk("eng_dst", 32'(eng_dst), 32'(d.dst));
    p = (plan_q.size() != 0) ? plan_q.pop_front() : rand_plan();
    n = 1;
    while (n != p.k && n <= int'(TIMEOUT) + 4) begin
      @(negedge clk);
      if (reset) begin
        eng_stop = 3'b000;
        return;
      end
      if (eng_start == 2'b00) break;
      if (eng_start != d.mode) fail("start_level", $sformatf("eng_start=%0d mode=%0d", eng_start, d.mode));
      n++;
    end
    if (p.k != 0) begin
      chk("run_cycles_before_stop", 32'(n), 32'(p.k));
      if (n != p.k) return;
      eng_stop = p.code;
      exp_q.push_back('{d.tag, p.code, 1'b0});
      #1 chk("start_drops_on_stop", 32'(eng_start), 32'd0);
      repeat (p.hold + 1) begin
        @(negedge clk);
        if (reset) begin
          eng_stop = 3'b000;
          return;
        end
        chk("drain_no_srst", 32'({eng_srst, eng_start}), 32'd0);
        chk("drain_length_stable", 32'(eng_length), 32'(d.len));
      end
      eng_stop = 3'b000;
    end else begin
      chk("run_cycles_to_timeout", 32'(n), 32'(TIMEOUT));
      exp_q.push_back('{d.tag, 3'b000, 1'b1});
      s = 0;
      while (eng_srst && s < int'(RST_CYCLES) + 8) begin
        s++;
        @(negedge clk);
        if (reset) return;
      end
      chk("srst_cycles", 32'(s), 32'(RST_CYCLES));
    end
  endtask

  initial begin : engine
    forever begin
      @(negedge clk);
      if (reset) eng_stop = 3'b000;
      else if (eng_start != 2'b00) run_job();
    end
  end

  initial begin : monitor
    ill_t  ie;
    done_t de;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (done_valid) begin
          if (done_status == 3'b111) begin
            if (ill_q.size() == 0) fail("ill_unexpected", $sformatf("tag=%0d", done_tag));
            else begin
              ie = ill_q.pop_front();
              chk("ill_tag", 32'(done_tag), 32'(ie.tag));
              chk("ill_timeout", 32'(done_timeout), 32'd0);
              chk("ill_latency_ok", 32'((cyc - ie.cyc == 1) || (cyc - ie.cyc == 2)), 32'd1);
            end
          end else begin
            if (exp_q.size() == 0) begin
              fail("done_unexpected", $sformatf("tag=%0d status=%0d timeout=%0d",
                                                done_tag, done_status, done_timeout));
            end else begin
              de = exp_q.pop_front();
              chk("done_tag", 32'(done_tag), 32'(de.tag));
              chk("done_status", 32'(done_status), 32'(de.status));
              chk("done_timeout", 32'(done_timeout), 32'(de.timeout));
            end
          end
        end else begin
          chk("done_idle_zero", 32'({done_tag, done_status, done_timeout}), 32'd0);
        end
      end
    end
  end

  task automatic push(logic [1:0] m, logic [8:0] l, logic [8:0] d);
    int g;
    @(negedge clk);
    job_valid = 1'b1;
    job_mode  = m;
    job_len   = l;
    job_dst   = d;
    g = 0;
    while (!job_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (!job_ready) begin
      fail("push_stuck", "job_ready never rose");
      job_valid = 1'b0;
      return;
    end
    chk("job_tag", 32'(job_tag), 32'(tag_model));
    if ((m == 2'b01 || m == 2'b10) && l != 9'd0) ldesc_q.push_back('{m, l, d, tag_model});
    else ill_q.push_back('{tag_model, cyc});
    tag_model = tag_model + 2'd1;
    @(posedge clk);
    #1 job_valid = 1'b0;
  endtask

  task automatic flush_model();
    ldesc_q.delete();
    exp_q.delete();
    ill_q.delete();
    plan_q.delete();
    tag_model = 2'd0;
  endtask

  task automatic apply_reset();
    job_valid = 1'b0;
    reset = 1'b1;
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_outputs_zero", 32'({job_tag, eng_start, eng_length, eng_dst, eng_srst, done_valid,
                                 done_tag, done_status, done_timeout, busy}), 32'd0);
  endtask

  task automatic wait_idle(string name);
    int g;
    g = 0;
    while ((busy || ldesc_q.size() != 0 || exp_q.size() != 0 || ill_q.size() != 0 ||
            eng_stop != 3'b000) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk(name, 32'(g < 3000), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    logic [1:0] m;
    logic [8:0] l;

    // Single job, engine reports 001 after 20 RUN cycles.
    apply_reset();
    plan_q.push_back('{20, 3'b001, 0});
    push(2'b01, 9'd4, 9'h040);
    wait_idle("single_job_idle");

    // Five back-to-back jobs against a stalled engine.
    apply_reset();
    plan_q.push_back('{30, 3'b001, 0});
    plan_q.push_back('{4, 3'b010, 1});
    plan_q.push_back('{2, 3'b011, 0});
    plan_q.push_back('{9, 3'b100, 2});
    plan_q.push_back('{1, 3'b101, 0});
    for (int i = 0; i < 5; i++) push(2'(1 + (i % 2)), 9'(10 + i), 9'(32 * i));
    chk("full_job_ready", 32'(job_ready), 32'd0);
    wait_idle("full_idle");

    // Illegal mode, then a legal job takes the next tag.
    apply_reset();
    push(2'b11, 9'd5, 9'h010);
    repeat (3) @(negedge clk);
    push(2'b01, 9'd2, 9'h020);
    wait_idle("illegal_idle");

    // Hung engine, then a queued job runs normally.
    apply_reset();
    plan_q.push_back('{0, 3'b000, 0});
    plan_q.push_back('{7, 3'b011, 1});
    push(2'b01, 9'd10, 9'h100);
    push(2'b10, 9'd20, 9'h0AA);
    wait_idle("timeout_idle");

    // Stop reported on the exact timeout cycle.
    plan_q.push_back('{int'(TIMEOUT), 3'b110, 0});
    push(2'b10, 9'd1, 9'h1FF);
    wait_idle("coincide_idle");

    // Reset while a job is running and another is queued.
    apply_reset();
    plan_q.push_back('{0, 3'b000, 0});
    push(2'b10, 9'd7, 9'h1AA);
    push(2'b01, 9'd3, 9'h055);
    repeat (6) @(negedge clk);
    chk("midrun_running", 32'(eng_start), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({job_tag, eng_start, eng_length, eng_dst, eng_srst, done_valid,
                                    done_tag, done_status, done_timeout, busy}), 32'd0);
    chk("async_reset_ready", 32'(job_ready), 32'd1);
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    chk("post_reset_quiet", 32'({eng_start, busy}), 32'd0);

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) m = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
      else m = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
      l = ($urandom_range(0, 19) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      push(m, l, 9'($urandom_range(0, 511)));
    end
    wait_idle("random_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
